// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared widths, arbiter state encoding and register decode helper
package cpu_defs;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ENTRY_W  = REG_W + DATA_W;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // r0 is hard-wired zero, so it never shows up as a pending target
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] rw);
        reg_onehot = '0;
        if (rw != '0) begin
            reg_onehot[rw] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO exposing every slot and its validity
module wb_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            valid,
    output logic [DEPTH-1:0][WIDTH-1:0] entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        do_push;
    logic                        do_pop;
    logic [PTR_W-1:0]            offset;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign entries = mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr_q;
            valid[i] = ({1'b0, offset} < count_q);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the RegFile write port between ALU and buffered MEM writebacks
module regfile_wb_arbiter
    import cpu_defs::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                alu_valid,
    input  logic [REG_W-1:0]    alu_rw,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [REG_W-1:0]    mem_rw,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    output logic                Write,
    output logic [REG_W-1:0]    Rw,
    output logic [DATA_W-1:0]   busW,
    output logic [NUM_REGS-1:0] pending
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e                    state_q, state_d;
    logic [SC_W-1:0]               starve_q, starve_d;
    logic                          write_q, write_d;
    logic [REG_W-1:0]              rw_q, rw_d;
    logic [DATA_W-1:0]             bus_q, bus_d;

    logic                          grant_alu;
    logic                          grant_mem;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [DEPTH-1:0]              fifo_valid;
    logic [DEPTH-1:0][ENTRY_W-1:0] fifo_entries;
    wb_entry_t                     fifo_din;
    wb_entry_t                     fifo_head;
    wb_entry_t                     slot;

    assign fifo_din  = '{rw: mem_rw, data: mem_data};
    assign mem_ready = ~fifo_full;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .push    (mem_valid),
        .pop     (grant_mem),
        .din     (fifo_din),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .valid   (fifo_valid),
        .entries (fifo_entries)
    );

    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        state_d   = state_q;
        starve_d  = starve_q;
        write_d   = 1'b0;
        rw_d      = rw_q;
        bus_d     = bus_q;
        alu_ready = (state_q == ST_NORMAL);

        if (state_q == ST_FORCE) begin
            grant_mem = ~fifo_empty;
        end else if (alu_valid) begin
            grant_alu = 1'b1;
        end else begin
            grant_mem = ~fifo_empty;
        end

        // r0 grants still consume the request but never strobe the RegFile
        if (grant_alu) begin
            rw_d    = alu_rw;
            bus_d   = alu_data;
            write_d = (alu_rw != '0);
        end else if (grant_mem) begin
            rw_d    = fifo_head.rw;
            bus_d   = fifo_head.data;
            write_d = (fifo_head.rw != '0);
        end

        if (grant_mem || fifo_empty) begin
            starve_d = '0;
        end else if (grant_alu) begin
            starve_d = starve_q + 1'b1;
            if (starve_q == SC_W'(STARVE_LIMIT - 1)) begin
                state_d = ST_FORCE;
            end
        end

        // FORCE lasts exactly one cycle so the ALU can never be locked out
        if (state_q == ST_FORCE) begin
            state_d = ST_NORMAL;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_NORMAL;
            starve_q <= '0;
            write_q  <= 1'b0;
            rw_q     <= '0;
            bus_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            write_q  <= write_d;
            rw_q     <= rw_d;
            bus_q    <= bus_d;
        end
    end

    assign Write = write_q;
    assign Rw    = rw_q;
    assign busW  = bus_q;

    always_comb begin
        pending = '0;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = fifo_entries[i];
            if (fifo_valid[i]) begin
                pending = pending | reg_onehot(slot.rw);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rw;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rw;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        Write;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [31:0] pending;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [36:0] sb[$];

    always #5 Clock = ~Clock;

    regfile_wb_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .alu_valid (alu_valid),
        .alu_rw    (alu_rw),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .Write     (Write),
        .Rw        (Rw),
        .busW      (busW),
        .pending   (pending)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rw, input logic [31:0] data);
        sb.push_back({rw, data});
    endtask

    // Every RegFile strobe must match the oldest expected write
    always @(negedge Clock) begin
        logic [36:0] exp;
        if (Reset_n === 1'b1 && Write === 1'b1) begin
            exp = 37'h1F_FFFF_FFFF;
            if (sb.size() > 0) exp = sb.pop_front();
            chk("wb_write", {27'b0, Rw, busW}, {27'b0, exp});
        end
    end

    initial begin
        Reset_n   = 1'b0;
        alu_valid = 1'b0;
        alu_rw    = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_rw    = '0;
        mem_data  = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_write", Write, 0);
        chk("reset_rw", Rw, 0);
        chk("reset_busw", busW, 0);
        chk("reset_mem_ready", mem_ready, 1);
        chk("reset_pending", pending, 0);
        chk("reset_alu_ready", alu_ready, 1);
        Reset_n = 1'b1;
        tick();

        // 1: reset with three MEM entries queued behind a busy ALU
        alu_valid = 1'b1;
        alu_rw    = 5'd10;
        for (int k = 0; k < 3; k++) begin
            alu_data  = 32'hC0 + k;
            mem_valid = 1'b1;
            mem_rw    = 5'(20 + k);
            mem_data  = 32'h2000 + k;
            expect_wr(5'd10, 32'hC0 + k);
            tick();
        end
        mem_valid = 1'b0;
        chk("t1_pending_queued", pending, 32'h0070_0000);
        @(negedge Clock);
        #1;
        Reset_n   = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("t1_write", Write, 0);
        chk("t1_pending", pending, 0);
        chk("t1_mem_ready", mem_ready, 1);
        tick();
        tick();
        Reset_n = 1'b1;
        repeat (6) tick();
        chk("t1_no_stale_writes", sb.size(), 0);

        // 2: ALU only
        alu_valid = 1'b1;
        alu_rw    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        chk("t2_alu_ready", alu_ready, 1);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        alu_valid = 1'b0;
        chk("t2_write", Write, 1);
        chk("t2_rw", Rw, 5);
        chk("t2_busw", busW, 32'hDEAD_BEEF);
        chk("t2_alu_ready_after", alu_ready, 1);
        tick();
        chk("t2_write_idle", Write, 0);
        chk("t2_rw_hold", Rw, 5);

        // 3: MEM only
        mem_valid = 1'b1;
        mem_rw    = 5'd7;
        mem_data  = 32'h1234;
        expect_wr(5'd7, 32'h1234);
        tick();
        mem_valid = 1'b0;
        chk("t3_pending_set", pending, 32'h80);
        tick();
        chk("t3_write", Write, 1);
        chk("t3_rw", Rw, 7);
        chk("t3_pending_clear", pending, 0);
        tick();

        // 4: starvation forces the queued MEM write
        alu_valid = 1'b1;
        alu_rw    = 5'd10;
        mem_valid = 1'b1;
        mem_rw    = 5'd9;
        mem_data  = 32'h99;
        for (int k = 0; k < 4; k++) begin
            alu_data = 32'hA0 + k;
            chk("t4_alu_ready_win", alu_ready, 1);
            expect_wr(5'd10, 32'hA0 + k);
            tick();
            mem_valid = 1'b0;
        end
        expect_wr(5'd9, 32'h99);
        alu_data = 32'hA4;
        chk("t4_alu_ready_forced", alu_ready, 0);
        tick();
        chk("t4_rw_mem", Rw, 9);
        chk("t4_alu_ready_resume", alu_ready, 1);
        expect_wr(5'd10, 32'hA4);
        tick();
        alu_valid = 1'b0;
        tick();

        // 5: fill the FIFO while the ALU hogs the port
        alu_valid = 1'b1;
        alu_rw    = 5'd10;
        for (int k = 0; k < 4; k++) begin
            alu_data  = 32'hB0 + k;
            mem_valid = 1'b1;
            mem_rw    = 5'(11 + k);
            mem_data  = 32'h500 + k;
            expect_wr(5'd10, 32'hB0 + k);
            tick();
        end
        chk("t5_mem_ready_full", mem_ready, 0);
        chk("t5_alu_ready_forced", alu_ready, 0);
        chk("t5_pending_full", pending, 32'h0000_7800);
        mem_rw   = 5'd15;
        mem_data = 32'hBAD;
        alu_data = 32'hB4;
        expect_wr(5'd11, 32'h500);
        tick();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        chk("t5_mem_ready_after_pop", mem_ready, 1);
        for (int k = 1; k < 4; k++) expect_wr(5'(11 + k), 32'h500 + k);
        repeat (3) tick();
        chk("t5_pending_drained", pending, 0);
        chk("t5_mem_ready_empty", mem_ready, 1);
        tick();

        // 6: ALU to r0 alongside a MEM write, then a MEM write to r0
        alu_valid = 1'b1;
        alu_rw    = 5'd0;
        alu_data  = 32'hFFFF;
        mem_valid = 1'b1;
        mem_rw    = 5'd3;
        mem_data  = 32'h33;
        expect_wr(5'd3, 32'h33);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk("t6_r0_write", Write, 0);
        chk("t6_pending", pending, 32'h8);
        tick();
        chk("t6_mem_write", Write, 1);
        chk("t6_pending_clear", pending, 0);
        mem_valid = 1'b1;
        mem_rw    = 5'd0;
        mem_data  = 32'h77;
        tick();
        mem_valid = 1'b0;
        chk("t6_r0_pending", pending, 0);
        tick();
        chk("t6_r0_mem_write", Write, 0);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
